// File: rtl/convenc_frame.sv
// convenc_frame: framed rate-1/N convolutional encoder with K-1 zero-tail termination; puncturing enabled by CONVENC_PUNCT_EN
module convenc_frame #(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] G = {3'b101, 3'b111},
  parameter int PUNCT_P = 2,
  parameter logic [PUNCT_P*N-1:0] PUNCT = 4'b0111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic [N-1:0] out_keep,
  output logic         out_last,
  output logic         busy
);
  typedef enum logic {DATA, TAIL} state_t;
  state_t state;
  logic [K-2:0] sr;
  logic [3:0] tail_cnt;
  logic [K-1:0] v;
  logic [N-1:0] y;
  logic b, load, step, fin;
`ifdef CONVENC_PUNCT_EN
  logic [2:0] slot;
`endif
  assign load = !out_valid || out_ready;
  assign in_ready = !rst && state == DATA && load;
  assign step = (state == DATA) ? in_valid && in_ready : load;
  assign fin = state == TAIL && tail_cnt == 4'd1;
  assign busy = state == TAIL;
  always_comb begin
    y = '0;
    b = (state == DATA) ? in_bit : 1'b0;
    v = {b, sr};
    for (int i = 0; i < N; i++) y[i] = ^(v & G[i*K +: K]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DATA;
      sr <= '0;
      tail_cnt <= '0;
      out_valid <= 1'b0;
      out_y <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
`ifdef CONVENC_PUNCT_EN
      slot <= '0;
`endif
    end else if (step) begin
      sr <= v[K-1:1];
      out_valid <= 1'b1;
      out_y <= y;
      out_last <= fin;
`ifdef CONVENC_PUNCT_EN
      out_keep <= PUNCT[slot*N +: N];
      slot <= (fin || slot == 3'(PUNCT_P - 1)) ? 3'd0 : slot + 3'd1;
`else
      out_keep <= '1;
`endif
      tail_cnt <= (state == DATA) ? 4'(K - 1) : tail_cnt - 4'd1;
      state <= (state == DATA) ? (in_last ? TAIL : DATA) : (fin ? DATA : TAIL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_keep <= '0;
      out_last <= 1'b0;
    end
  end
endmodule

// File: tb/tb_convenc_frame.sv
// tb_convenc_frame: directed checks of framing, tail flush, backpressure, back-to-back, reset and puncturing
module tb_convenc_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, busy;
  logic [1:0] out_y, out_keep;
  logic in_valid7 = 1'b0, in_bit7 = 1'b0, in_last7 = 1'b0, out_ready7 = 1'b1;
  logic in_ready7, out_valid7, out_last7, busy7;
  logic [1:0] out_y7, out_keep7;
  int checks = 0, fails = 0;
  int bp_mode = 0, bp_idx = 0;
  int stall_bad = 0, stall_cnt = 0, busy_cyc = 0, busy_rdy = 0, b2b_hit = 0;
  logic [4:0] q[$];
  logic [4:0] held = '0;
  logic was_stalled = 1'b0;
  logic [1:0] f1 [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  logic [1:0] f2 [4] = '{2'b11, 2'b01, 2'b01, 2'b11};
  logic [1:0] f3 [3] = '{2'b11, 2'b10, 2'b11};
  convenc_frame dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_keep(out_keep), .out_last(out_last), .busy(busy)
  );
  convenc_frame #(.K(7), .N(2), .G({7'b1011011, 7'b1111001})) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7), .in_bit(in_bit7),
    .in_last(in_last7), .out_valid(out_valid7), .out_ready(out_ready7), .out_y(out_y7),
    .out_keep(out_keep7), .out_last(out_last7), .busy(busy7)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    out_ready = (bp_mode == 0) || (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
    bp_idx++;
  end
  always @(negedge clk) begin
    if (out_valid && out_ready) q.push_back({out_last, out_keep, out_y});
    if (was_stalled && held !== {out_last, out_keep, out_y}) stall_bad++;
    if (out_valid && !out_ready) begin
      stall_cnt++;
      if (in_ready) stall_bad++;
    end
    was_stalled = out_valid && !out_ready;
    held = {out_last, out_keep, out_y};
    if (busy) begin
      busy_cyc++;
      if (in_ready) busy_rdy++;
    end
    if (in_valid && in_ready && out_valid && out_ready && out_last) b2b_hit++;
  end
  function automatic logic [1:0] exp_keep(input int i);
`ifdef CONVENC_PUNCT_EN
    return (i % 2 == 0) ? 2'b11 : 2'b01;
`else
    return 2'b11;
`endif
  endfunction
  task automatic send(input logic bit_v, input logic last_v);
    int t = 0;
    in_valid = 1'b1;
    in_bit = bit_v;
    in_last = last_v;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_words(input int n);
    int t = 0;
    while (q.size() < n && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (q.size() < n) begin
      fails++;
      $display("FAIL wait_words: got %0d words, required %0d", q.size(), n);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_y, out_keep, out_last, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 0", {out_valid, out_y, out_keep, out_last, busy});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    checks++;
    if ({out_valid7, out_last7, busy7, in_ready7} !== 4'b0) begin
      fails++;
      $display("FAIL reset_k7: got %b, required 0", {out_valid7, out_last7, busy7, in_ready7});
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic;
    int s = q.size();
    int bc = busy_cyc;
    int br = busy_rdy;
    logic [4:0] w;
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    wait_words(s + 6);
    for (int i = 0; i < 6 && s + i < q.size(); i++) begin
      w = q[s + i];
      checks++;
      if ({w[0], w[1]} !== f1[i]) begin
        fails++;
        $display("FAIL basic_y[%0d]: got y0y1=%b%b, required %b", i, w[0], w[1], f1[i]);
      end
      checks++;
      if (w[4] !== (i == 5)) begin
        fails++;
        $display("FAIL basic_last[%0d]: got %b, required %b", i, w[4], i == 5);
      end
      checks++;
      if (w[3:2] !== exp_keep(i)) begin
        fails++;
        $display("FAIL basic_keep[%0d]: got %b, required %b", i, w[3:2], exp_keep(i));
      end
    end
    checks++;
    if (busy_cyc - bc !== 2) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d, required 2", busy_cyc - bc);
    end
    checks++;
    if (busy_rdy - br !== 0) begin
      fails++;
      $display("FAIL basic_tail_in_ready: got %0d ready cycles, required 0", busy_rdy - br);
    end
  endtask
  task automatic test_k7;
    logic [6:0] e0 = 7'b1111001;
    logic [6:0] e1 = 7'b1011011;
    in_valid7 = 1'b1;
    in_bit7 = 1'b1;
    in_last7 = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready7 !== 1'b1) begin
      fails++;
      $display("FAIL k7_in_ready: got %b, required 1", in_ready7);
    end
    @(posedge clk);
    #1;
    in_valid7 = 1'b0;
    in_last7 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid7, out_y7[0], out_y7[1], out_last7} !== {1'b1, e0[6-i], e1[6-i], i == 6}) begin
        fails++;
        $display("FAIL k7_word[%0d]: got valid,y0,y1,last=%b%b%b%b, required %b%b%b%b", i,
                 out_valid7, out_y7[0], out_y7[1], out_last7, 1'b1, e0[6-i], e1[6-i], i == 6);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid7 !== 1'b0) begin
      fails++;
      $display("FAIL k7_extra_word: out_valid=%b, required 0", out_valid7);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_backpressure;
    int s = q.size();
    int sb = stall_bad;
    int sc = stall_cnt;
    logic [4:0] w;
    bp_mode = 1;
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    wait_words(s + 6);
    bp_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() - s !== 6) begin
      fails++;
      $display("FAIL bp_word_count: got %0d, required 6", q.size() - s);
    end
    for (int i = 0; i < 6 && s + i < q.size(); i++) begin
      w = q[s + i];
      checks++;
      if ({w[0], w[1], w[4]} !== {f1[i], i == 5}) begin
        fails++;
        $display("FAIL bp_word[%0d]: got y0y1,last=%b%b%b, required %b%b", i, w[0], w[1], w[4], f1[i], i == 5);
      end
    end
    checks++;
    if (stall_cnt - sc < 2) begin
      fails++;
      $display("FAIL bp_stalls_seen: got %0d, required >=2", stall_cnt - sc);
    end
    checks++;
    if (stall_bad - sb !== 0) begin
      fails++;
      $display("FAIL bp_stall_stability: got %0d violations, required 0", stall_bad - sb);
    end
  endtask
  task automatic test_back_to_back;
    int s = q.size();
    int bh = b2b_hit;
    logic [4:0] w;
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    send(1, 0); send(1, 1);
    wait_words(s + 10);
    for (int i = 0; i < 10 && s + i < q.size(); i++) begin
      w = q[s + i];
      checks++;
      if ({w[0], w[1]} !== (i < 6 ? f1[i] : f2[i-6]) || w[4] !== (i == 5 || i == 9)) begin
        fails++;
        $display("FAIL b2b_word[%0d]: got y0y1,last=%b%b%b, required %b%b", i, w[0], w[1], w[4],
                 i < 6 ? f1[i] : f2[i-6], i == 5 || i == 9);
      end
      checks++;
      if (w[3:2] !== exp_keep(i < 6 ? i : i - 6)) begin
        fails++;
        $display("FAIL b2b_keep[%0d]: got %b, required %b", i, w[3:2], exp_keep(i < 6 ? i : i - 6));
      end
    end
    checks++;
    if (b2b_hit - bh !== 1) begin
      fails++;
      $display("FAIL b2b_accept_on_last: got %0d, required 1", b2b_hit - bh);
    end
  endtask
  task automatic test_reset_mid_tail;
    int s = q.size();
    int lasts = 0;
    logic [4:0] w;
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_y, out_keep, out_last, busy, in_ready} !== 8'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got %b, required 0", {out_valid, out_y, out_keep, out_last, busy, in_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = s; i < q.size(); i++) lasts += int'(q[i][4]);
    checks++;
    if (lasts !== 0) begin
      fails++;
      $display("FAIL midreset_no_last: got %0d last words, required 0", lasts);
    end
    s = q.size();
    send(1, 1);
    wait_words(s + 3);
    for (int i = 0; i < 3 && s + i < q.size(); i++) begin
      w = q[s + i];
      checks++;
      if ({w[0], w[1], w[4]} !== {f3[i], i == 2}) begin
        fails++;
        $display("FAIL midreset_word[%0d]: got y0y1,last=%b%b%b, required %b%b", i, w[0], w[1], w[4], f3[i], i == 2);
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_k7;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_tail;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
